uart_tx_buffered: RTL and testbench

- UART transmitter, 8N1, LSB first; the transmit counterpart of the board's UART receive path.
- Bytes are accepted through a valid/ready write port into a small synchronous FIFO, then serialised back-to-back onto o_TX_Serial.
- Sits between host-side logic (loopback, debug, status reporting) and the board's UART TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit and receive paths.
// No logic; elaboration-time constants only.
// No flow control of its own.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Bit-period counter width; at least one bit even when CLKS_PER_BIT is tiny.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Latency: a written word is visible on o_Rd_Data the cycle after the write.
// Backpressure: writes while full and reads while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_Wr_En,
    input  logic [WIDTH-1:0]             i_Wr_Data,
    input  logic                         i_Rd_En,
    output logic [WIDTH-1:0]             o_Rd_Data,
    output logic                         o_Full,
    output logic                         o_Empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_n;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = i_Wr_En & ~o_Full;
    assign rd_ok = i_Rd_En & ~o_Empty;

    always_comb begin
        count_n = o_Count;
        if (wr_ok && !rd_ok) begin
            count_n = o_Count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_n = o_Count - CW'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_Clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
            o_Full  <= 1'b0;
            o_Empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_Count <= count_n;
            o_Full  <= (count_n == CW'(DEPTH));
            o_Empty <= (count_n == '0);
        end
    end

    assign o_Rd_Data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first, frames sent back-to-back from a FIFO.
// Latency: byte written at edge N into an empty idle block drives the start bit after edge N+1.
// Backpressure: o_TX_Ready low while the FIFO is full; writes then are dropped and flagged on o_Overflow.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_L,
    input  logic                              i_TX_DV,
    input  logic [7:0]                        i_TX_Byte,
    output logic                              o_TX_Ready,
    output logic                              o_TX_Serial,
    output logic                              o_TX_Active,
    output logic                              o_TX_Done,
    output logic                              o_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_FIFO_Count
);

    localparam int             CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 serial_n;
    logic                 active_n;
    logic                 done_n;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    assign o_TX_Ready = ~fifo_full;
    assign push       = i_TX_DV & ~fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (push),
        .i_Wr_Data (i_TX_Byte),
        .i_Rd_En   (pop),
        .o_Rd_Data (fifo_data),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty),
        .o_Count   (o_FIFO_Count)
    );

    // Line level is computed one cycle ahead so that o_TX_Serial is a flop.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        serial_n  = o_TX_Serial;
        active_n  = o_TX_Active;
        done_n    = 1'b0;
        pop       = 1'b0;

        unique case (state)
            IDLE: begin
                serial_n = 1'b1;
                active_n = 1'b0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_data;
                    clk_cnt_n = '0;
                    state_n   = START;
                    serial_n  = 1'b0;
                    active_n  = 1'b1;
                end
            end
            START: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                    serial_n  = shift[0];
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_n  = STOP;
                        serial_n = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        serial_n  = shift[bit_idx + 3'd1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_n = '0;
                    done_n    = 1'b1;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop      = 1'b1;
                        shift_n  = fifo_data;
                        state_n  = START;
                        serial_n = 1'b0;
                    end else begin
                        state_n  = IDLE;
                        active_n = 1'b0;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = 1'b1;
                active_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
            o_Overflow  <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            o_TX_Serial <= serial_n;
            o_TX_Active <= active_n;
            o_TX_Done   <= done_n;
            o_Overflow  <= i_TX_DV & fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: main instance at CLKS_PER_BIT=4, second at 2.
// Sample index j means "value seen at the falling edge after write edge N+j".
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int CPB2  = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          dv    = 1'b0;
    logic [7:0]    tx_byte = 8'h00;
    logic          ready, serial, active, done, ovf;
    logic [CW-1:0] count;
    logic          dv2   = 1'b0;
    logic [7:0]    tx_byte2 = 8'h00;
    logic          ready2, serial2, active2, done2, ovf2;
    logic [CW-1:0] count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready), .o_TX_Serial(serial), .o_TX_Active(active),
        .o_TX_Done(done), .o_Overflow(ovf), .o_FIFO_Count(count)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv2), .i_TX_Byte(tx_byte2),
        .o_TX_Ready(ready2), .o_TX_Serial(serial2), .o_TX_Active(active2),
        .o_TX_Done(done2), .o_Overflow(ovf2), .o_FIFO_Count(count2)
    );

    // Expected line level at cycle pos (0-based) of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int pos, input int cpb);
        int slot;
        slot = pos / cpb;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic test_reset();
        int bad_done;
        int bad_line;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial got %b want 1", serial); end
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_tests++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active); end
        n_tests++;
        if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++;
        if (done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses done=%b ovf=%b want 0 0", done, ovf);
        end
        rst_n = 1'b1;
        bad_done = 0;
        bad_line = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || done2 !== 1'b0) bad_done++;
            if (serial !== 1'b1 || serial2 !== 1'b1 || active !== 1'b0) bad_line++;
        end
        n_tests++;
        if (bad_done != 0) begin n_fail++; $display("FAIL reset_no_done got %0d pulses want 0", bad_done); end
        n_tests++;
        if (bad_line != 0) begin n_fail++; $display("FAIL reset_idle_line got %0d bad cycles want 0", bad_line); end
    endtask

    task automatic test_single();
        logic e_ser;
        for (int j = -1; j <= 48; j++) begin
            @(negedge clk);
            if (j >= 0) begin
                e_ser = (j >= 1 && j <= 40) ? frame_bit(8'hA5, j - 1, CPB) : 1'b1;
                n_tests++;
                if (serial !== e_ser) begin
                    n_fail++; $display("FAIL single_serial j=%0d got %b want %b", j, serial, e_ser);
                end
                n_tests++;
                if (active !== (j >= 1 && j <= 40)) begin
                    n_fail++; $display("FAIL single_active j=%0d got %b", j, active);
                end
                n_tests++;
                if (done !== (j == 41)) begin
                    n_fail++; $display("FAIL single_done j=%0d got %b", j, done);
                end
            end
            dv      = (j + 1 == 0);
            tx_byte = 8'hA5;
        end
        dv = 1'b0;
    endtask

    task automatic test_overflow_burst();
        logic e_ser;
        int   f;
        int   dones;
        int   ovfs;
        dones = 0;
        ovfs  = 0;
        for (int j = -1; j <= 370; j++) begin
            @(negedge clk);
            if (j >= 0) begin
                f = (j - 1) / 40;
                e_ser = (j >= 1 && j <= 360) ? frame_bit(8'(f), (j - 1) % 40, CPB) : 1'b1;
                n_tests++;
                if (serial !== e_ser) begin
                    n_fail++; $display("FAIL burst_serial j=%0d got %b want %b", j, serial, e_ser);
                end
                n_tests++;
                if (active !== (j >= 1 && j <= 360)) begin
                    n_fail++; $display("FAIL burst_active j=%0d got %b", j, active);
                end
                n_tests++;
                if (done !== (j >= 41 && j <= 361 && (j - 1) % 40 == 0)) begin
                    n_fail++; $display("FAIL burst_done j=%0d got %b", j, done);
                end
                n_tests++;
                if (ovf !== (j == 9)) begin
                    n_fail++; $display("FAIL burst_overflow j=%0d got %b", j, ovf);
                end
                if (done === 1'b1) dones++;
                if (ovf === 1'b1) ovfs++;
                if (j == 8) begin
                    n_tests++;
                    if (count !== CW'(8)) begin n_fail++; $display("FAIL burst_full_count got %0d want 8", count); end
                    n_tests++;
                    if (ready !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready got %b want 0", ready); end
                end
                if (j == 9) begin
                    n_tests++;
                    if (count !== CW'(8)) begin n_fail++; $display("FAIL burst_drop_count got %0d want 8", count); end
                end
                if (j == 41) begin
                    n_tests++;
                    if (ready !== 1'b1 || count !== CW'(7)) begin
                        n_fail++; $display("FAIL burst_after_pop ready=%b count=%0d want 1 7", ready, count);
                    end
                end
            end
            dv      = (j + 1 >= 0 && j + 1 <= 9);
            tx_byte = 8'(j + 1);
        end
        dv = 1'b0;
        n_tests++;
        if (dones != 9) begin n_fail++; $display("FAIL burst_done_total got %0d want 9", dones); end
        n_tests++;
        if (ovfs != 1) begin n_fail++; $display("FAIL burst_ovf_total got %0d want 1", ovfs); end
    endtask

    task automatic test_write_mid_frame();
        logic e_ser;
        for (int j = -1; j <= 90; j++) begin
            @(negedge clk);
            if (j >= 0) begin
                if (j >= 1 && j <= 40)       e_ser = frame_bit(8'h3C, j - 1, CPB);
                else if (j >= 41 && j <= 80) e_ser = frame_bit(8'h7E, j - 41, CPB);
                else                         e_ser = 1'b1;
                n_tests++;
                if (serial !== e_ser) begin
                    n_fail++; $display("FAIL midwrite_serial j=%0d got %b want %b", j, serial, e_ser);
                end
                n_tests++;
                if (active !== (j >= 1 && j <= 80)) begin
                    n_fail++; $display("FAIL midwrite_active j=%0d got %b", j, active);
                end
                n_tests++;
                if (done !== (j == 41 || j == 81)) begin
                    n_fail++; $display("FAIL midwrite_done j=%0d got %b", j, done);
                end
            end
            // Second write lands on edge N+18, inside data bit 3 of the first frame.
            dv      = (j + 1 == 0 || j + 1 == 18);
            tx_byte = (j + 1 == 18) ? 8'h7E : 8'h3C;
        end
        dv = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic e_ser;
        int   bad;
        for (int j = -1; j <= 26; j++) begin
            @(negedge clk);
            if (j >= 0) begin
                e_ser = (j >= 1) ? frame_bit(8'h55, j - 1, CPB) : 1'b1;
                n_tests++;
                if (serial !== e_ser) begin
                    n_fail++; $display("FAIL rstmid_serial j=%0d got %b want %b", j, serial, e_ser);
                end
            end
            dv      = (j + 1 == 0 || j + 1 == 1);
            tx_byte = (j + 1 == 1) ? 8'hAA : 8'h55;
        end
        dv = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (serial !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_serial got %b want 1", serial); end
        n_tests++;
        if (active !== 1'b0 || count !== '0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async_state active=%b count=%0d ready=%b want 0 0 1", active, count, ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (serial !== 1'b1 || done !== 1'b0 || active !== 1'b0 || count !== '0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_discard got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_short_bit();
        logic e_ser;
        for (int j = -1; j <= 26; j++) begin
            @(negedge clk);
            if (j >= 0) begin
                e_ser = (j == 1 || j == 2) ? 1'b0 : 1'b1;
                n_tests++;
                if (serial2 !== e_ser) begin
                    n_fail++; $display("FAIL cpb2_serial j=%0d got %b want %b", j, serial2, e_ser);
                end
                n_tests++;
                if (done2 !== (j == 21)) begin
                    n_fail++; $display("FAIL cpb2_done j=%0d got %b", j, done2);
                end
                n_tests++;
                if (active2 !== (j >= 1 && j <= 20)) begin
                    n_fail++; $display("FAIL cpb2_active j=%0d got %b", j, active2);
                end
            end
            dv2      = (j + 1 == 0);
            tx_byte2 = 8'hFF;
        end
        dv2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow_burst();
        test_write_mid_frame();
        test_reset_mid_frame();
        test_short_bit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
